midi_note_sender: RTL and testbench

- Downstream stage of seq_player. Consumes its pulse_send_note/midi_note pair and returns busy as back-pressure.
- For each accepted note, serialises a MIDI Note On message (3 bytes) on a 31250-baud UART line.
- Holds the note for a fixed gate time, then sends the matching Note Off message (3 bytes).
- The only external output is the MIDI TX serial line.

---
 rtl/midi_note_sender.sv | 152 +++++++++++++++
 tb/tb_midi_note_sender.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_sender.sv
// MIDI note sender: serialises Note On, waits a fixed gate time, then Note Off
// on a UART line; reports busy to the upstream sequencer as back-pressure.
module midi_note_sender #(
    parameter int unsigned CLKS_PER_BIT = 3200,
    parameter int unsigned GATE_CYCLES  = 5_000_000,
    parameter int unsigned CHANNEL      = 0,
    parameter int unsigned VELOCITY     = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pulse_send_note,
    input  logic [7:0] midi_note,
    output logic       busy,
    output logic       midi_tx,
    output logic       note_active
);

    localparam int unsigned TMR_W       = $clog2(CLKS_PER_BIT);
    localparam int unsigned GATE_W      = $clog2(GATE_CYCLES + 1);
    localparam int unsigned REST_CYCLES = 60 * CLKS_PER_BIT + GATE_CYCLES;
    localparam int unsigned REST_W      = $clog2(REST_CYCLES + 1);

    localparam logic [3:0]        CHAN      = 4'(CHANNEL);
    localparam logic [6:0]        VEL       = 7'(VELOCITY);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [REST_W-1:0] REST_LAST = REST_W'(REST_CYCLES - 1);
    localparam logic [3:0]        STOP_IDX  = 4'd9;
    localparam logic [1:0]        LAST_BYTE = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        ON_TX,
        GATE,
        OFF_TX,
        REST
    } state_t;

    state_t              state_q;
    logic [TMR_W-1:0]    bit_tmr_q;
    logic [3:0]          bit_idx_q;
    logic [1:0]          byte_idx_q;
    logic [GATE_W-1:0]   gate_cnt_q;
    logic [REST_W-1:0]   rest_cnt_q;
    logic [6:0]          note_q;

    logic [7:0]          cur_byte_c;
    logic                next_bit_c;
    logic                bit_end_c;
    logic                note_msb_unused;

    assign note_msb_unused = midi_note[7];

    // Byte currently on the wire, selected by message type and position
    always_comb begin
        cur_byte_c = 8'h00;
        case (byte_idx_q)
            2'd0:    cur_byte_c = (state_q == OFF_TX) ? {4'h8, CHAN} : {4'h9, CHAN};
            2'd1:    cur_byte_c = {1'b0, note_q};
            2'd2:    cur_byte_c = (state_q == OFF_TX) ? 8'h00 : {1'b0, VEL};
            default: cur_byte_c = 8'h00;
        endcase
    end

    // Slot following the current one: data bits LSB first, then the stop bit
    assign next_bit_c = (bit_idx_q < 4'd8) ? cur_byte_c[bit_idx_q[2:0]] : 1'b1;
    assign bit_end_c  = (bit_tmr_q == TMR_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_tmr_q   <= '0;
            bit_idx_q   <= '0;
            byte_idx_q  <= '0;
            gate_cnt_q  <= '0;
            rest_cnt_q  <= '0;
            note_q      <= '0;
            busy        <= 1'b0;
            midi_tx     <= 1'b1;
            note_active <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pulse_send_note && !busy) begin
                        note_q     <= midi_note[6:0];
                        busy       <= 1'b1;
                        bit_tmr_q  <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                        rest_cnt_q <= '0;
                        if (midi_note[6:0] != 7'd0) begin
                            state_q     <= ON_TX;
                            midi_tx     <= 1'b0;
                            note_active <= 1'b1;
                        end else begin
                            state_q <= REST;
                        end
                    end
                end

                ON_TX, OFF_TX: begin
                    if (!bit_end_c) begin
                        bit_tmr_q <= bit_tmr_q + TMR_W'(1);
                    end else begin
                        bit_tmr_q <= '0;
                        if (bit_idx_q != STOP_IDX) begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            midi_tx   <= next_bit_c;
                        end else if (byte_idx_q != LAST_BYTE) begin
                            // Next byte follows immediately with its start bit
                            byte_idx_q <= byte_idx_q + 2'd1;
                            bit_idx_q  <= '0;
                            midi_tx    <= 1'b0;
                        end else if (state_q == ON_TX) begin
                            state_q    <= GATE;
                            gate_cnt_q <= '0;
                        end else begin
                            state_q     <= IDLE;
                            busy        <= 1'b0;
                            note_active <= 1'b0;
                        end
                    end
                end

                GATE: begin
                    if (gate_cnt_q == GATE_LAST) begin
                        state_q    <= OFF_TX;
                        midi_tx    <= 1'b0;
                        bit_tmr_q  <= '0;
                        bit_idx_q  <= '0;
                        byte_idx_q <= '0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                    end
                end

                REST: begin
                    // Silent slot with the same busy length as a sounded note
                    if (rest_cnt_q == REST_LAST) begin
                        state_q <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        rest_cnt_q <= rest_cnt_q + REST_W'(1);
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_midi_note_sender.sv
// Directed bench for midi_note_sender: a UART receiver decodes midi_tx and the
// decoded bytes, their start cycles and busy/note_active timing are compared.
module tb_midi_note_sender;

    localparam int CPB      = 4;
    localparam int GATE     = 20;
    localparam int BUSY_CYC = 60 * CPB + GATE;

    logic       clk = 1'b0;
    logic       rst;
    logic       pulse;
    logic [7:0] note;
    logic       busy0, tx0, na0;
    logic       busy9, tx9, na9;
    logic [1:0] tx_v;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign tx_v = {tx9, tx0};

    midi_note_sender #(.CLKS_PER_BIT(CPB), .GATE_CYCLES(GATE), .CHANNEL(0), .VELOCITY(100)) dut0 (
        .clk(clk), .rst(rst), .pulse_send_note(pulse), .midi_note(note),
        .busy(busy0), .midi_tx(tx0), .note_active(na0)
    );

    midi_note_sender #(.CLKS_PER_BIT(CPB), .GATE_CYCLES(GATE), .CHANNEL(9), .VELOCITY(100)) dut9 (
        .clk(clk), .rst(rst), .pulse_send_note(pulse), .midi_note(note),
        .busy(busy9), .midi_tx(tx9), .note_active(na9)
    );

    typedef struct {
        logic       id;
        logic [7:0] b;
        int         st;
        logic       stop;
    } rx_t;

    typedef struct {
        logic [7:0] note_in;
        logic [7:0] exp_note;
        logic       exp_rest;
    } vec_t;

    rx_t  rxq[$];
    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic wait_neg(input int n, inout logic ok);
        repeat (n) begin
            @(negedge clk);
            if (rst) ok = 1'b0;
        end
    endtask

    // UART receiver; frames interrupted by reset are discarded
    task automatic mon(input logic id);
        logic [7:0] b;
        logic       ok;
        logic       stop;
        int         st;
        forever begin
            @(negedge clk);
            if (!rst && tx_v[id] == 1'b0) begin
                st = cyc;
                ok = 1'b1;
                b  = 8'h00;
                wait_neg(CPB / 2, ok);
                if (tx_v[id] != 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    wait_neg(CPB, ok);
                    b = {tx_v[id], b[7:1]};
                end
                wait_neg(CPB, ok);
                stop = tx_v[id];
                if (ok) rxq.push_back('{id, b, st, stop});
            end
        end
    endtask

    initial mon(1'b0);
    initial mon(1'b1);

    function automatic int count_id(input logic id);
        int n = 0;
        foreach (rxq[i]) if (rxq[i].id == id) n++;
        return n;
    endfunction

    task automatic pop_id(input logic id, output rx_t e, output logic found);
        found = 1'b0;
        e     = '{id, 8'h00, 0, 1'b0};
        for (int i = 0; i < rxq.size() && !found; i++) begin
            if (rxq[i].id == id) begin
                e     = rxq[i];
                found = 1'b1;
                rxq.delete(i);
            end
        end
    endtask

    task automatic check_msgs(input logic id, input int acc, input logic [7:0] exp_note,
                              input logic [3:0] ch, input logic rest, input string tag);
        logic [7:0] eb[6];
        int         eo[6];
        rx_t        e;
        logic       found;
        eb[0] = {4'h9, ch}; eb[1] = exp_note; eb[2] = 8'h64;
        eb[3] = {4'h8, ch}; eb[4] = exp_note; eb[5] = 8'h00;
        eo[0] = 0;               eo[1] = 10 * CPB;        eo[2] = 20 * CPB;
        eo[3] = 30 * CPB + GATE; eo[4] = 40 * CPB + GATE; eo[5] = 50 * CPB + GATE;
        if (rest) begin
            chk($sformatf("%s ch%0d rest byte count", tag, ch), count_id(id), 0);
        end else begin
            for (int k = 0; k < 6; k++) begin
                pop_id(id, e, found);
                chk($sformatf("%s ch%0d byte%0d present", tag, ch, k), int'(found), 1);
                if (found) begin
                    chk($sformatf("%s ch%0d byte%0d value", tag, ch, k), int'(e.b), int'(eb[k]));
                    chk($sformatf("%s ch%0d byte%0d start", tag, ch, k), e.st - acc, eo[k]);
                    chk($sformatf("%s ch%0d byte%0d stop", tag, ch, k), int'(e.stop), 1);
                end
            end
        end
    endtask

    // Call at a negedge; returns at the negedge after the acceptance edge
    task automatic send(input logic [7:0] n, output int acc);
        pulse = 1'b1;
        note  = n;
        @(negedge clk);
        pulse = 1'b0;
        acc   = cyc;
    endtask

    task automatic measure(input logic scramble, input string tag, output int bcnt,
                           output int b9cnt, output int nacnt, output int lowcnt);
        int guard = 0;
        bcnt = 0; b9cnt = 0; nacnt = 0; lowcnt = 0;
        while ((busy0 || busy9) && guard < 2000) begin
            if (busy0) bcnt++;
            if (busy9) b9cnt++;
            if (na0)   nacnt++;
            if (!tx0)  lowcnt++;
            @(negedge clk);
            if (scramble) note = 8'($urandom);
            guard++;
        end
        chk($sformatf("%s busy ends within bound", tag), int'(guard < 2000), 1);
    endtask

    initial begin
        int acc, acc2, bcnt, b9cnt, nacnt, lowcnt, bad;
        logic found;
        rx_t e;

        vecs[0] = '{8'd60,  8'h3C, 1'b0};
        vecs[1] = '{8'hBC,  8'h3C, 1'b0};
        vecs[2] = '{8'h00,  8'h00, 1'b1};
        vecs[3] = '{8'h7F,  8'h7F, 1'b0};
        vecs[4] = '{8'h80,  8'h00, 1'b1};
        vecs[5] = '{8'h01,  8'h01, 1'b0};

        rst = 1'b1; pulse = 1'b0; note = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy0), 0);
        chk("reset midi_tx", int'(tx0), 1);
        chk("reset note_active", int'(na0), 0);
        chk("reset midi_tx ch9", int'(tx9), 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle midi_tx", int'(tx0), 1);
        chk("idle busy", int'(busy0), 0);

        // Table of single notes and rests
        for (int v = 0; v < 6; v++) begin
            send(vecs[v].note_in, acc);
            chk($sformatf("vec%0d busy after accept", v), int'(busy0), 1);
            measure(1'b0, $sformatf("vec%0d", v), bcnt, b9cnt, nacnt, lowcnt);
            chk($sformatf("vec%0d busy cycles", v), bcnt, BUSY_CYC);
            chk($sformatf("vec%0d busy cycles ch9", v), b9cnt, BUSY_CYC);
            chk($sformatf("vec%0d note_active cycles", v), nacnt, vecs[v].exp_rest ? 0 : BUSY_CYC);
            if (vecs[v].exp_rest)
                chk($sformatf("vec%0d rest midi_tx low cycles", v), lowcnt, 0);
            check_msgs(1'b0, acc, vecs[v].exp_note, 4'h0, vecs[v].exp_rest, $sformatf("vec%0d", v));
            check_msgs(1'b1, acc, vecs[v].exp_note, 4'h9, vecs[v].exp_rest, $sformatf("vec%0d", v));
            repeat (3) @(negedge clk);
        end

        // Back-pressure: pulses every 10 cycles while busy, one on the falling edge
        // of busy (dropped) and one the cycle after (accepted)
        send(8'd60, acc);
        bcnt = 0;
        for (int k = 1; k <= BUSY_CYC + 1; k++) begin
            if (busy0) bcnt++;
            if (k == BUSY_CYC + 1) chk("bp busy low at fall", int'(busy0), 0);
            pulse = ((k % 10) == 0) || (k == BUSY_CYC + 1);
            note  = 8'd72;
            @(negedge clk);
        end
        pulse = 1'b0;
        acc2  = cyc;
        chk("bp first busy cycles", bcnt, BUSY_CYC);
        chk("bp accepted after fall", int'(busy0), 1);
        measure(1'b0, "bp2", bcnt, b9cnt, nacnt, lowcnt);
        chk("bp second busy cycles", bcnt, BUSY_CYC);
        check_msgs(1'b0, acc, 8'h3C, 4'h0, 1'b0, "bp1");
        check_msgs(1'b0, acc2, 8'h48, 4'h0, 1'b0, "bp2");
        check_msgs(1'b1, acc, 8'h3C, 4'h9, 1'b0, "bp1");
        check_msgs(1'b1, acc2, 8'h48, 4'h9, 1'b0, "bp2");
        chk("bp no extra bytes", rxq.size(), 0);
        repeat (3) @(negedge clk);

        // Reset during data bit 1 of the Note On note byte (0x3C: bit value 0)
        send(8'd60, acc);
        repeat (49) @(negedge clk);
        chk("rst pre midi_tx", int'(tx0), 0);
        rst = 1'b1;
        #1;
        chk("rst async midi_tx", int'(tx0), 1);
        chk("rst async busy", int'(busy0), 0);
        chk("rst async note_active", int'(na0), 0);
        chk("rst async midi_tx ch9", int'(tx9), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (tx_v != 2'b11 || busy0 || busy9) bad++;
        end
        chk("rst quiet after abort", bad, 0);
        chk("rst partial msg bytes", count_id(1'b0), 1);
        pop_id(1'b0, e, found);
        chk("rst first byte value", int'(e.b), 8'h90);
        chk("rst first byte start", e.st - acc, 0);
        pop_id(1'b1, e, found);
        chk("rst first byte value ch9", int'(e.b), 8'h99);
        chk("rst no other bytes", rxq.size(), 0);
        send(8'd60, acc);
        measure(1'b0, "post-rst", bcnt, b9cnt, nacnt, lowcnt);
        chk("post-rst busy cycles", bcnt, BUSY_CYC);
        check_msgs(1'b0, acc, 8'h3C, 4'h0, 1'b0, "post-rst");
        check_msgs(1'b1, acc, 8'h3C, 4'h9, 1'b0, "post-rst");
        repeat (3) @(negedge clk);

        // Note latch: midi_note scrambled every cycle while busy
        send(8'h15, acc);
        measure(1'b1, "latch", bcnt, b9cnt, nacnt, lowcnt);
        chk("latch busy cycles", bcnt, BUSY_CYC);
        check_msgs(1'b0, acc, 8'h15, 4'h0, 1'b0, "latch");
        check_msgs(1'b1, acc, 8'h15, 4'h9, 1'b0, "latch");
        repeat (50) @(negedge clk);
        chk("final queue empty", rxq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
